// File: rtl/riscv_pkg.sv
// riscv_pkg: shared state, opcode and datapath select encodings for the multicycle control unit
package riscv_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps alu_op and instruction funct fields to an ALU operation
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       funct_legal
);
  logic [2:0] funct_op;
  // funct3 selects the operation; funct7b5 means sub only for R-type (op5 set)
  always_comb begin
    funct_legal = funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b110 || funct3 == 3'b111;
    funct_op    = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010 ? ALU_SLT : funct3 == 3'b110 ? ALU_OR : ALU_AND;
    alu_control = alu_op == ALUOP_SUB ? ALU_SUB : alu_op == ALUOP_FUNCT ? funct_op : ALU_ADD;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle RV32I-subset Moore FSM driving datapath enables and mux selects
module control_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic        reg_write,
  output logic        illegal
);
  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [6:0] op;
  logic [1:0] alu_op;
  logic       funct_legal, pc_update, branch, req_c, irw_c, rw_c;

  assign op = instr[6:0];

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (instr[14:12]),
    .funct7b5    (instr[30]),
    .op5         (instr[5]),
    .alu_control (alu_control),
    .funct_legal (funct_legal)
  );

  // next state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    mem_write  = 1'b0;
    irw_c      = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    rw_c       = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        irw_c      = mem_ready;
        pc_update  = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
                    op == OP_RTYPE  ? (funct_legal ? S_EXECR : S_TRAP) :
                    op == OP_ITYPE  ? (funct_legal ? S_EXECI : S_TRAP) :
                    op == OP_BRANCH ? S_BEQ : op == OP_JAL ? S_JAL : S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c   = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        rw_c       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c     = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // state and sticky trap flag; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_req   = req_c & resetn;
  assign ir_write  = irw_c & resetn;
  assign pc_write  = (pc_update | (branch & zero)) & resetn;
  assign reg_write = rw_c & resetn;
  assign imm_src   = imm_sel(op);
  assign illegal   = illegal_q;
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle RISC-V control unit for the RV32I subset (lw, sw, R-type ALU, I-type ALU, beq, jal). It decodes the instruction register and sequences the datapath through fetch/decode/execute/memory/writeback states. It drives every datapath enable and mux select, including `imm_src` for the immediate extender, and inserts wait states on a simple memory ready handshake.

## Interface
Parameters:
- none.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction register contents; fields used: [6:0] opcode, [14:12] funct3, [30] funct7b5.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `mem_write`  out  1  the requested access is a store.
- `ir_write`  out  1  latch fetched word into IR and old_pc.
- `pc_write`  out  1  PC load enable (`pc_update | (branch & zero)`).
- `adr_src`  out  1  0 = PC, 1 = result.
- `alu_src_a`  out  2  00 = PC, 01 = old_pc, 10 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = imm_ext, 10 = constant 4.
- `result_src`  out  2  00 = alu_out register, 01 = read data, 10 = ALU result.
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 J.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  unsupported opcode trapped; sticky.

## Operation
- Moore FSM. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10.
  - If `mem_ready` is high, assert `ir_write` and `pc_update`, then go to DECODE.
  - Otherwise hold with `ir_write` and `pc_write` at 0.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, add (computes the branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - anything else → TRAP.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `mem_req`=1, `adr_src`=1, `result_src`=00. Go to MEMWB on `mem_ready`, else hold.
- MEMWB: `result_src`=01, `reg_write`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1, `result_src`=00. Go to FETCH on `mem_ready`, else hold.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, ALU op from funct. Then ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, ALU op from funct. Then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, then FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, sub, `branch`=1, `result_src`=00. Then FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_update`=1. Then ALUWB (rd ← old_pc+4).
- TRAP: all enables 0, `illegal`=1. Stays in TRAP until reset.
- ALU decode (funct3):
  - 000: add. Exception: R-type with funct7b5=1 is sub; I-type ignores funct7b5.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3 in R/I-type → TRAP from DECODE.
- `imm_src` is combinational from opcode in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Outputs not listed for a state are 0.

## Timing
- Reset (async, `resetn`=0): state ← FETCH, `illegal` ← 0. While `resetn` is low, `mem_req`, `ir_write`, `pc_write` and `reg_write` are forced 0. The first fetch request is issued in the first cycle after `resetn` rises.
- Reset asserted mid-instruction aborts it immediately; no partial writes occur after reset asserts.
- Cycles per instruction, assuming `mem_ready` high on first request: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each low `mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Handshake:
  - `mem_req` is held and `mem_write`/`adr_src` are stable until the cycle `mem_ready`=1; the transfer completes on that edge.
  - `mem_ready` outside a request is ignored.
- `pc_write` in BEQ depends combinationally on `zero` in the same cycle.

## Structure
- Shared package `riscv_pkg`:
  - state enum.
  - opcode constants (`OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_BRANCH`, `OP_JAL`).
  - `imm_src` encodings (`IMM_I`/`IMM_S`/`IMM_B`/`IMM_J`).
  - `alu_control` encodings.
  - mux-select encodings.
- One sub-module: `alu_decoder`. It is purely combinational (alu_op, funct3, funct7b5, opcode bit 5 → `alu_control`, `funct_legal`).

## Test plan
- Reset then 0x00500093 (addi x1,x0,5) with `mem_ready`=1 → states FETCH, DECODE, EXECI, ALUWB.
  - In EXECI: `imm_src`=00, `alu_src_b`=01, `alu_control`=000.
  - In ALUWB: `reg_write`=1.
  - Back in FETCH on cycle 5.
- 0x0040A103 (lw) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `reg_write` only in MEMWB with `result_src`=01.
- 0x00202423 (sw) → `imm_src`=01, `mem_write`=1 with `adr_src`=1 in MEMWRITE, `reg_write` never asserted.
- 0x00000463 (beq): with `zero`=1, `pc_write`=1 in BEQ and `imm_src`=10; with `zero`=0, `pc_write`=0. 3 cycles either way.
- 0x010000EF (jal) → `imm_src`=11, `pc_write` in JAL, `reg_write` in ALUWB. Also 0x402081B3 → sub (001) in EXECR.
- Opcode 0x0000007F → TRAP, `illegal`=1 held indefinitely. `resetn` pulse mid-TRAP → FETCH, `illegal`=0.
